// File: rtl/sysbus_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : sysbus_pkg
//  Purpose  : Shared types and tag-layout constants for the system-bus arbiter.
//  Revision : 1.0 - initial release
// ============================================================================
package sysbus_pkg;

    typedef enum logic [1:0] {
        ARB_IDLE = 2'd0,
        ARB_REQ  = 2'd1,
        ARB_RESP = 2'd2
    } arb_state_t;

    // Bus tag layout: {rd(1), unit(4), id(8)}
    localparam int TAG_RD_BIT   = 12;
    localparam int TAG_UNIT_LSB = 8;
    localparam int TAG_UNIT_W   = 4;
    localparam int TAG_ID_LSB   = 0;
    localparam int TAG_ID_W     = 8;

    localparam logic [TAG_UNIT_W-1:0] SYSBUS_MEMORY = 4'h1;

    localparam logic CL_IFETCH = 1'b0;
    localparam logic CL_LOAD   = 1'b1;

endpackage : sysbus_pkg
`default_nettype wire

// File: rtl/sysbus_arbiter_if.sv
`default_nettype none
// ============================================================================
//  Module   : sysbus_client_if / sysbus_bus_if
//  Purpose  : Client-side (fetch/load) and bus-side signal bundles of the arbiter.
//  Revision : 1.0 - initial release
// ============================================================================
interface sysbus_client_if #(
    parameter int DW = 64
);
    logic [1:0]         cl_req;
    logic [1:0][DW-1:0] cl_addr;
    logic [1:0]         cl_gnt;
    logic [1:0]         cl_rvalid;
    logic [DW-1:0]      cl_rdata;
    logic [1:0]         cl_rack;
    logic               cl_last;

    // master = the requesting core units, slave = the arbiter
    modport master (
        output cl_req, cl_addr, cl_rack,
        input  cl_gnt, cl_rvalid, cl_rdata, cl_last
    );
    modport slave (
        input  cl_req, cl_addr, cl_rack,
        output cl_gnt, cl_rvalid, cl_rdata, cl_last
    );
endinterface : sysbus_client_if

interface sysbus_bus_if #(
    parameter int DW = 64,
    parameter int TW = 13
);
    logic          bus_reqcyc;
    logic [DW-1:0] bus_req;
    logic [TW-1:0] bus_reqtag;
    logic          bus_respack;
    logic          bus_reqack;
    logic          bus_respcyc;
    logic [DW-1:0] bus_resp;
    logic [TW-1:0] bus_resptag;

    // master = the arbiter, slave = the system bus
    modport master (
        output bus_reqcyc, bus_req, bus_reqtag, bus_respack,
        input  bus_reqack, bus_respcyc, bus_resp, bus_resptag
    );
    modport slave (
        input  bus_reqcyc, bus_req, bus_reqtag, bus_respack,
        output bus_reqack, bus_respcyc, bus_resp, bus_resptag
    );
endinterface : sysbus_bus_if
`default_nettype wire

// File: rtl/sysbus_arbiter_rr_pick2.sv
`default_nettype none
// ============================================================================
//  Module   : rr_pick2
//  Purpose  : Combinational 2-way round-robin picker; on a tie the client that
//             was not granted last wins.
//  Revision : 1.0 - initial release
// ============================================================================
module rr_pick2 (
    input  logic [1:0] req_i,
    input  logic       last_i,
    output logic       idx_o,
    output logic       any_o
);

    always_comb begin
        any_o = |req_i;
        idx_o = (req_i == 2'b11) ? ~last_i : req_i[1];
    end

endmodule : rr_pick2
`default_nettype wire

// File: rtl/sysbus_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : sysbus_arbiter
//  Purpose  : Shares the system-bus read master between instruction fetch (0)
//             and data load (1); one burst transaction of BEATS beats at a time.
//  Revision : 1.0 - initial release
// ============================================================================
module sysbus_arbiter
    import sysbus_pkg::*;
#(
    parameter int BUS_DATA_WIDTH = 64,
    parameter int BUS_TAG_WIDTH  = 13,
    parameter int BEATS          = 8    // must be a power of 2
) (
    input  logic           clk,
    input  logic           reset,
    sysbus_client_if.slave cl,
    sysbus_bus_if.master   bus,
    output logic           tag_err
);

    localparam int                BEAT_W    = (BEATS > 1) ? $clog2(BEATS) : 1;
    localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(BEATS - 1);

    arb_state_t                state_q, state_d;
    logic                      owner_q, owner_d;
    logic                      last_grant_q, last_grant_d;
    logic [BEAT_W-1:0]         beat_q, beat_d;
    logic [BUS_DATA_WIDTH-1:0] addr_q, addr_d;
    logic                      tag_err_q, tag_err_d;

    logic                      w_pick_idx;
    logic                      w_pick_any;
    logic [BUS_TAG_WIDTH-1:0]  w_req_tag;
    logic                      w_id_mismatch;
    logic                      w_beat_accept;
    logic                      w_unused_resptag;

    logic [1:0]                w_gnt;
    logic [1:0]                w_rvalid;
    logic [BUS_DATA_WIDTH-1:0] w_rdata;
    logic                      w_last;
    logic                      w_reqcyc;
    logic [BUS_DATA_WIDTH-1:0] w_req;
    logic [BUS_TAG_WIDTH-1:0]  w_reqtag;
    logic                      w_respack;

    rr_pick2 u_pick (
        .req_i  (cl.cl_req),
        .last_i (last_grant_q),
        .idx_o  (w_pick_idx),
        .any_o  (w_pick_any)
    );

    always_comb begin
        w_req_tag                                = '0;
        w_req_tag[TAG_RD_BIT]                    = 1'b1;
        w_req_tag[TAG_UNIT_LSB +: TAG_UNIT_W]    = SYSBUS_MEMORY;
        w_req_tag[TAG_ID_LSB +: TAG_ID_W]        = TAG_ID_W'(owner_q);
    end

    // Only the id field identifies the owner; rd/unit bits are not checked.
    assign w_id_mismatch    = bus.bus_resptag[TAG_ID_LSB +: TAG_ID_W] != TAG_ID_W'(owner_q);
    assign w_unused_resptag = &{1'b0, bus.bus_resptag[BUS_TAG_WIDTH-1:TAG_ID_LSB+TAG_ID_W]};

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= ARB_IDLE;
            owner_q      <= 1'b0;
            last_grant_q <= 1'b1;
            beat_q       <= '0;
            addr_q       <= '0;
            tag_err_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            owner_q      <= owner_d;
            last_grant_q <= last_grant_d;
            beat_q       <= beat_d;
            addr_q       <= addr_d;
            tag_err_q    <= tag_err_d;
        end
    end

    always_comb begin
        state_d       = state_q;
        owner_d       = owner_q;
        last_grant_d  = last_grant_q;
        beat_d        = beat_q;
        addr_d        = addr_q;
        tag_err_d     = tag_err_q;

        w_gnt         = 2'b00;
        w_rvalid      = 2'b00;
        w_rdata       = '0;
        w_last        = 1'b0;
        w_reqcyc      = 1'b0;
        w_req         = '0;
        w_reqtag      = '0;
        w_respack     = 1'b0;
        w_beat_accept = 1'b0;

        case (state_q)
            ARB_IDLE: begin
                if (w_pick_any) begin
                    owner_d = w_pick_idx;
                    addr_d  = cl.cl_addr[w_pick_idx];
                    state_d = ARB_REQ;
                end
            end

            ARB_REQ: begin
                w_reqcyc = 1'b1;
                w_req    = addr_q;
                w_reqtag = w_req_tag;
                if (bus.bus_reqack) begin
                    w_gnt[owner_q] = 1'b1;
                    last_grant_d   = owner_q;
                    beat_d         = '0;
                    state_d        = ARB_RESP;
                end
            end

            ARB_RESP: begin
                w_rvalid[owner_q] = bus.bus_respcyc;
                w_rdata           = bus.bus_resp;
                w_last            = (beat_q == LAST_BEAT);
                w_beat_accept     = bus.bus_respcyc & cl.cl_rack[owner_q];
                w_respack         = w_beat_accept;
                // A mismatched beat is still forwarded and counted.
                if (bus.bus_respcyc && w_id_mismatch) begin
                    tag_err_d = 1'b1;
                end
                if (w_beat_accept) begin
                    beat_d = beat_q + BEAT_W'(1);
                    if (beat_q == LAST_BEAT) begin
                        state_d = ARB_IDLE;
                    end
                end
            end

            default: begin
                state_d = ARB_IDLE;
            end
        endcase
    end

    assign cl.cl_gnt       = w_gnt;
    assign cl.cl_rvalid    = w_rvalid;
    assign cl.cl_rdata     = w_rdata;
    assign cl.cl_last      = w_last;
    assign bus.bus_reqcyc  = w_reqcyc;
    assign bus.bus_req     = w_req;
    assign bus.bus_reqtag  = w_reqtag;
    assign bus.bus_respack = w_respack;
    assign tag_err         = tag_err_q;

endmodule : sysbus_arbiter
`default_nettype wire

// File: tb/tb_sysbus_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : tb_sysbus_arbiter
//  Purpose  : Directed scoreboard bench for sysbus_arbiter.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_sysbus_arbiter;

    localparam int DW    = 64;
    localparam int TW    = 13;
    localparam int BEATS = 8;

    typedef struct {
        bit          is_beat;
        bit          client;
        logic [63:0] data;
        bit          last;
    } exp_t;

    logic clk = 1'b0;
    logic reset;
    logic tag_err;

    int   vectors     = 0;
    int   miscompares = 0;
    int   txn_id      = 0;
    exp_t sb[$];
    exp_t mon_e;

    always #5 clk = ~clk;

    sysbus_client_if #(.DW(DW))          cif ();
    sysbus_bus_if    #(.DW(DW), .TW(TW)) bif ();

    sysbus_arbiter #(
        .BUS_DATA_WIDTH (DW),
        .BUS_TAG_WIDTH  (TW),
        .BEATS          (BEATS)
    ) dut (
        .clk     (clk),
        .reset   (reset),
        .cl      (cif),
        .bus     (bif),
        .tag_err (tag_err)
    );

    function automatic logic [1:0] oh(input bit c);
        return c ? 2'b10 : 2'b01;
    endfunction

    function automatic logic [63:0] beat_data(input int t, input int b);
        return {16'hBEA7, t[15:0], 24'h0, b[7:0]};
    endfunction

    task automatic chk(input string name, input logic [159:0] act, input logic [159:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h, want %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Monitor: pops the scoreboard on every grant pulse and accepted beat.
    always @(negedge clk) begin
        if (!reset) begin
            if (cif.cl_gnt != 2'b00) begin
                if (sb.size() == 0) begin
                    chk("gnt_unexpected", {158'h0, cif.cl_gnt}, 160'h0);
                end else begin
                    mon_e = sb.pop_front();
                    chk("gnt", {mon_e.is_beat, cif.cl_gnt}, {1'b0, oh(mon_e.client)});
                end
            end
            if (bif.bus_respack) begin
                if (sb.size() == 0) begin
                    chk("beat_unexpected", {159'h0, bif.bus_respack}, 160'h0);
                end else begin
                    mon_e = sb.pop_front();
                    chk("beat", {mon_e.is_beat, cif.cl_rvalid, cif.cl_rdata, cif.cl_last},
                        {1'b1, oh(mon_e.client), mon_e.data, mon_e.last});
                end
            end
        end
    end

    // Runs one transaction from the bus side; returns at the negedge of the cycle
    // after the final beat (or right after beat abort_at-1 if aborting).
    task automatic serve(input bit owner, input logic [63:0] addr, input int ack_delay,
                         input logic [7:0] stall_mask, input int bad_beat, input bit err0,
                         input bit keep_req, input int abort_at, input int raise_other_at,
                         output int waited);
        logic [12:0] tag;
        bit          seen_bad;
        tag      = 13'h1100 | 13'(owner);
        seen_bad = err0;
        waited   = 0;
        txn_id++;
        @(negedge clk);
        while (bif.bus_reqcyc !== 1'b1) begin
            if (waited >= 40) begin
                chk("reqcyc_timeout", {159'h0, bif.bus_reqcyc}, 160'h1);
                return;
            end
            waited++;
            @(negedge clk);
        end
        for (int k = 0; k < ack_delay; k++) begin
            if (k > 0) @(negedge clk);
            chk("req_hold", {bif.bus_reqcyc, bif.bus_reqtag, bif.bus_req}, {1'b1, tag, addr});
            @(posedge clk); #1;
        end
        bif.bus_reqack = 1'b1;
        sb.push_back('{is_beat: 1'b0, client: owner, data: 64'h0, last: 1'b0});
        @(negedge clk);
        chk("req_ack_cycle", {bif.bus_reqcyc, bif.bus_reqtag, bif.bus_req}, {1'b1, tag, addr});
        @(posedge clk); #1;
        bif.bus_reqack = 1'b0;
        if (!keep_req) cif.cl_req[owner] = 1'b0;
        @(negedge clk);
        chk("reqcyc_drop", {159'h0, bif.bus_reqcyc}, 160'h0);
        for (int b = 0; b < BEATS; b++) begin
            if (b == abort_at) return;
            if (stall_mask[b]) begin
                @(posedge clk); #1;
                if (b == raise_other_at) cif.cl_req[!owner] = 1'b1;
                bif.bus_respcyc = 1'b1;
                bif.bus_resp    = beat_data(txn_id, b);
                bif.bus_resptag = {1'b1, 4'h1, 7'h0, owner};
                cif.cl_rack     = oh(!owner);
                @(negedge clk);
                chk("stall_respack", {bif.bus_respack, cif.cl_rvalid}, {1'b0, oh(owner)});
            end
            @(posedge clk); #1;
            if (b == raise_other_at) cif.cl_req[!owner] = 1'b1;
            bif.bus_respcyc = 1'b1;
            bif.bus_resp    = beat_data(txn_id, b);
            bif.bus_resptag = {1'b1, 4'h1, 7'h0, (b == bad_beat) ? !owner : owner};
            cif.cl_rack     = 2'b11;
            sb.push_back('{is_beat: 1'b1, client: owner, data: beat_data(txn_id, b),
                           last: (b == BEATS - 1)});
            @(negedge clk);
            chk("tag_err_track", {159'h0, tag_err}, {159'h0, seen_bad});
            if (b == bad_beat) seen_bad = 1'b1;
        end
        @(posedge clk); #1;
        bif.bus_respcyc = 1'b0;
        bif.bus_resp    = '0;
        bif.bus_resptag = '0;
        cif.cl_rack     = 2'b00;
        @(negedge clk);
        chk("idle_after", {bif.bus_reqcyc, cif.cl_last, cif.cl_rvalid}, 160'h0);
    endtask

    task automatic chk_all_zero(input string name);
        chk(name, {cif.cl_gnt, cif.cl_rvalid, cif.cl_rdata, cif.cl_last, tag_err}, 160'h0);
        chk(name, {bif.bus_reqcyc, bif.bus_req, bif.bus_reqtag, bif.bus_respack}, 160'h0);
    endtask

    task automatic pulse_reset();
        @(posedge clk); #1;
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, %0d vectors", vectors);
        $fatal(1);
    end

    initial begin
        int w;
        reset           = 1'b1;
        cif.cl_req      = 2'b00;
        cif.cl_addr     = '0;
        cif.cl_rack     = 2'b00;
        bif.bus_reqack  = 1'b0;
        bif.bus_respcyc = 1'b0;
        bif.bus_resp    = '0;
        bif.bus_resptag = '0;

        // Reset state
        #3;
        chk_all_zero("reset_outputs");
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;

        // Single fetch, ack after 3 cycles
        cif.cl_addr[0] = 64'h1000;
        cif.cl_req     = 2'b01;
        @(negedge clk);
        chk("idle_no_bus", {159'h0, bif.bus_reqcyc}, 160'h0);
        serve(1'b0, 64'h1000, 3, 8'h00, -1, 1'b0, 1'b0, -1, -1, w);
        chk("fetch_req_next_cycle", 160'(w), 160'h0);

        // Contention from reset: strict alternation 0,1,0 then 1
        pulse_reset();
        cif.cl_addr[0] = 64'h2000;
        cif.cl_addr[1] = 64'h3000;
        cif.cl_req     = 2'b11;
        serve(1'b0, 64'h2000, 1, 8'h00, -1, 1'b0, 1'b1, -1, -1, w);
        serve(1'b1, 64'h3000, 2, 8'h00, -1, 1'b0, 1'b1, -1, -1, w);
        chk("alt_b2b_gap", 160'(w), 160'h0);
        serve(1'b0, 64'h2000, 1, 8'h00, -1, 1'b0, 1'b0, -1, -1, w);
        serve(1'b1, 64'h3000, 1, 8'h00, -1, 1'b0, 1'b0, -1, -1, w);

        // Backpressure on beats 2..4 for the load port
        @(posedge clk); #1;
        cif.cl_addr[1] = 64'h4040;
        cif.cl_req     = 2'b10;
        serve(1'b1, 64'h4040, 1, 8'b0001_1100, -1, 1'b0, 1'b0, -1, -1, w);

        // Tag mismatch on beat 5, owner 1
        @(posedge clk); #1;
        cif.cl_addr[1] = 64'h5080;
        cif.cl_req     = 2'b10;
        serve(1'b1, 64'h5080, 2, 8'h00, 5, 1'b0, 1'b0, -1, -1, w);
        repeat (3) @(negedge clk);
        chk("tag_err_sticky", {159'h0, tag_err}, 160'h1);

        // Reset in the middle of the response phase
        @(posedge clk); #1;
        cif.cl_addr[0] = 64'h6000;
        cif.cl_req     = 2'b01;
        serve(1'b0, 64'h6000, 1, 8'h00, -1, 1'b1, 1'b0, 3, -1, w);
        @(posedge clk); #1;
        bif.bus_respcyc = 1'b1;
        bif.bus_resp    = 64'hDEAD_BEEF_0000_0003;
        bif.bus_resptag = 13'h1100;
        cif.cl_rack     = 2'b11;
        #1;
        chk("resp_live_before_reset", {bif.bus_respack, cif.cl_rvalid}, {1'b1, 2'b01});
        reset = 1'b1;
        #1;
        chk_all_zero("async_reset_outputs");
        @(posedge clk); @(posedge clk); #1;
        reset = 1'b0;
        repeat (2) begin
            @(negedge clk);
            chk("stray_beat_not_acked", {bif.bus_respack, cif.cl_rvalid}, 160'h0);
        end
        @(posedge clk); #1;
        bif.bus_respcyc = 1'b0;
        cif.cl_rack     = 2'b00;
        cif.cl_addr[0]  = 64'h7000;
        cif.cl_addr[1]  = 64'h7100;
        cif.cl_req      = 2'b11;
        serve(1'b0, 64'h7000, 1, 8'h00, -1, 1'b0, 1'b0, -1, -1, w);
        serve(1'b1, 64'h7100, 1, 8'h00, -1, 1'b0, 1'b0, -1, -1, w);

        // Late load request arriving during fetch response
        @(posedge clk); #1;
        cif.cl_addr[0] = 64'h8000;
        cif.cl_addr[1] = 64'h8800;
        cif.cl_req     = 2'b01;
        serve(1'b0, 64'h8000, 1, 8'h00, -1, 1'b0, 1'b0, -1, 2, w);
        serve(1'b1, 64'h8800, 1, 8'h00, -1, 1'b0, 1'b0, -1, -1, w);
        chk("late_req_gap", 160'(w), 160'h0);

        repeat (3) @(negedge clk);
        chk("scoreboard_drained", 160'(sb.size()), 160'h0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule : tb_sysbus_arbiter
`default_nettype wire
